// File: rtl/manchester_pkg.sv
// Shared encodings, default framing bytes and FSM state type for the Manchester receive path.
package manchester_pkg;

  localparam logic [1:0] CHIP_ONE  = 2'b10;
  localparam logic [1:0] CHIP_ZERO = 2'b01;

  localparam logic [7:0] PREAMBLE_BYTE_DEF = 8'hAA;
  localparam logic [7:0] SFD_BYTE_DEF      = 8'hD5;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } rx_state_e;

endpackage

// File: rtl/manchester_pair_decode.sv
// Combinational chip-pair decoder: 8 chips (bit 7 earliest) to 4 bits (bit 3 earliest) plus per-bit valid.
module manchester_pair_decode
  import manchester_pkg::*;
(
  input  logic [7:0] chips,
  output logic [3:0] bits,
  output logic [3:0] bits_ok
);

  for (genvar i = 0; i < 4; i++) begin : g_pair
    assign bits[i]    = (chips[2*i +: 2] == CHIP_ONE);
    assign bits_ok[i] = (chips[2*i +: 2] == CHIP_ONE) || (chips[2*i +: 2] == CHIP_ZERO);
  end

endmodule

// File: rtl/manchester_rx_decoder.sv
// Manchester receive decoder: two-phase preamble/SFD hunt, then fixed-length payload byte assembly.
// Optional frame/error counters are built when MANCH_RX_STATS_EN is defined.
module manchester_rx_decoder
  import manchester_pkg::*;
#(
  parameter int          PAYLOAD_BYTES = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = PREAMBLE_BYTE_DEF,
  parameter logic [7:0]  SFD_BYTE      = SFD_BYTE_DEF
) (
  input  logic        clk108,
  input  logic        aresetn,
  input  logic [7:0]  chip_word,
  input  logic        chip_valid,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_start,
  output logic        frame_end,
  output logic        code_err,
  output logic        locked
`ifdef MANCH_RX_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam logic [15:0] SYNC     = {PREAMBLE_BYTE, SFD_BYTE};
  localparam logic [7:0]  LAST_IDX = 8'(PAYLOAD_BYTES - 1);

  rx_state_e        state_q, state_d;
  logic             prev_chip_q;
  logic             lock_ph_q;
  logic [7:0]       sr_q;
  logic [2:0]       cnt_q;
  logic [7:0]       idx_q;
  logic [1:0][15:0] hist_q, hist_ok_q;

  logic [1:0][7:0]  ph_chips;
  logic [1:0][3:0]  ph_bits, ph_ok;
  logic [1:0][3:0]  hit;

  // Phase 1 pairs straddle the word boundary by one chip.
  assign ph_chips[0] = chip_word;
  assign ph_chips[1] = {prev_chip_q, chip_word[7:1]};

  for (genvar p = 0; p < 2; p++) begin : g_ph
    logic [19:0] ext, ext_ok;

    manchester_pair_decode u_dec (
      .chips   (ph_chips[p]),
      .bits    (ph_bits[p]),
      .bits_ok (ph_ok[p])
    );

    assign ext    = {hist_q[p], ph_bits[p]};
    assign ext_ok = {hist_ok_q[p], ph_ok[p]};

    // Offset o leaves o bits of this word after the SFD.
    for (genvar o = 0; o < 4; o++) begin : g_off
      assign hit[p][o] = (ext[o +: 16] == SYNC) && (&ext_ok[o +: 16]);
    end
  end

  logic       sel_hit, sel_ph;
  logic [1:0] sel_off;

  // Later assignments win, so iterate from lowest to highest priority.
  always_comb begin
    sel_hit = 1'b0;
    sel_ph  = 1'b0;
    sel_off = 2'd0;
    for (int p = 1; p >= 0; p--) begin
      for (int o = 3; o >= 0; o--) begin
        if (hit[p][o]) begin
          sel_hit = 1'b1;
          sel_ph  = 1'(p);
          sel_off = 2'(o);
        end
      end
    end
  end

  logic [3:0] run_bits, run_ok, run_mask;
  logic [7:0] w_sr, w_idx, w_data;
  logic [2:0] w_cnt;
  logic       w_emit, w_first, w_last, w_err, w_active;

  // Walk the word's bits in time order through the byte assembler.
  always_comb begin
    run_bits = ph_bits[lock_ph_q];
    run_ok   = ph_ok[lock_ph_q];
    run_mask = 4'hF;
    w_sr     = sr_q;
    w_cnt    = cnt_q;
    w_idx    = idx_q;
    if (state_q == HUNT) begin
      run_bits = ph_bits[sel_ph];
      run_ok   = ph_ok[sel_ph];
      run_mask = (4'd1 << sel_off) - 4'd1;
      w_sr     = 8'd0;
      w_cnt    = 3'd0;
      w_idx    = 8'd0;
    end
    w_active = 1'b1;
    w_emit   = 1'b0;
    w_first  = 1'b0;
    w_last   = 1'b0;
    w_err    = 1'b0;
    w_data   = 8'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_active && run_mask[i]) begin
        if (!run_ok[i]) begin
          w_err    = 1'b1;
          w_active = 1'b0;
        end else begin
          w_sr = {w_sr[6:0], run_bits[i]};
          if (w_cnt == 3'd7) begin
            w_emit  = 1'b1;
            w_data  = w_sr;
            w_first = (w_idx == 8'd0);
            w_last  = (w_idx == LAST_IDX);
            w_cnt   = 3'd0;
            if (w_idx == LAST_IDX) w_active = 1'b0;
            else                   w_idx    = w_idx + 8'd1;
          end else begin
            w_cnt = w_cnt + 3'd1;
          end
        end
      end
    end
  end

  logic go, emit_d, end_d, err_d;

  assign go     = chip_valid && ((state_q == PAYLOAD) || sel_hit);
  assign emit_d = go && w_emit;
  assign end_d  = go && w_emit && w_last;
  assign err_d  = go && w_err;

  always_ff @(posedge clk108 or negedge aresetn) begin
    if (!aresetn) state_q <= HUNT;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (chip_valid) begin
      case (state_q)
        HUNT:    if (sel_hit && !w_err)  state_d = PAYLOAD;
        PAYLOAD: if (w_err || w_last)    state_d = HUNT;
        default:                         state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    locked = (state_q == PAYLOAD);
  end

  always_ff @(posedge clk108 or negedge aresetn) begin
    if (!aresetn) begin
      prev_chip_q <= 1'b0;
      lock_ph_q   <= 1'b0;
      sr_q        <= 8'd0;
      cnt_q       <= 3'd0;
      idx_q       <= 8'd0;
      hist_q      <= '0;
      hist_ok_q   <= '0;
      byte_data   <= 8'd0;
      byte_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      byte_valid  <= emit_d;
      frame_start <= emit_d && w_first;
      frame_end   <= end_d;
      code_err    <= err_d;
      if (emit_d) byte_data <= w_data;
      if (chip_valid) begin
        prev_chip_q <= chip_word[0];
        if (go) begin
          sr_q  <= w_sr;
          cnt_q <= w_cnt;
          idx_q <= w_idx;
          if (state_q == HUNT) lock_ph_q <= sel_ph;
        end
        // History only accumulates while hunting; any lock or frame exit restarts it empty.
        for (int p = 0; p < 2; p++) begin
          if (state_q == HUNT && !sel_hit) begin
            hist_q[p]    <= {hist_q[p][11:0], ph_bits[p]};
            hist_ok_q[p] <= {hist_ok_q[p][11:0], ph_ok[p]};
          end else begin
            hist_ok_q[p] <= 16'd0;
          end
        end
      end
    end
  end

`ifdef MANCH_RX_STATS_EN
  always_ff @(posedge clk108 or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt <= 16'd0;
      err_cnt   <= 16'd0;
    end else begin
      frame_cnt <= frame_cnt + 16'(end_d);
      err_cnt   <= err_cnt + 16'(err_d);
    end
  end
`endif

endmodule
